// File: rtl/adder_seq_wide.sv
// ---------------------------------------------------------------------------
// adder_seq_wide
//   Multi-cycle wide adder. Two WORDS*64-bit operands are summed one 64-bit
//   word per cycle (least significant word first) through a single shared
//   adder_64bit instance. The carry between words is held in a register.
//   Both the request side and the result side use a valid/ready handshake.
//
// Optional feature macro: ADDER_SEQ_SUB_EN
//   When defined, the inSub port is added. inSub=1 computes A-B as A+~B+1,
//   and outCarry=1 then means "no borrow" (A >= B unsigned).
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   inValid   request valid
//   outReady  sequencer idle and able to accept a request
//   inA, inB  W-bit operands, captured on the accept edge
//   inCarry   carry into word 0, captured on the accept edge
//   inSub     (ADDER_SEQ_SUB_EN only) subtract select, captured on accept
//   outValid  result valid
//   inReady   consumer takes the result
//   outSum    W-bit sum, stable while outValid=1
//   outCarry  carry out of the top word, stable while outValid=1
//   outBusy   operation in progress or result waiting
// ---------------------------------------------------------------------------

// 64-bit adder slice shared by every word of the wide operation.
module adder_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'd0, cin};

endmodule

module adder_seq_wide #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inValid,
  output logic                  outReady,
  input  logic [64*WORDS-1:0]   inA,
  input  logic [64*WORDS-1:0]   inB,
  input  logic                  inCarry,
`ifdef ADDER_SEQ_SUB_EN
  input  logic                  inSub,
`endif
  output logic                  outValid,
  input  logic                  inReady,
  output logic [64*WORDS-1:0]   outSum,
  output logic                  outCarry,
  output logic                  outBusy
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          next_state;
  logic [IDXW-1:0] idx_q;
  logic            carry_q;
  logic            cout_q;
  logic [63:0]     a_words   [WORDS];
  logic [63:0]     b_words   [WORDS];
  logic [63:0]     sum_words [WORDS];
  logic [63:0]     add_a;
  logic [63:0]     add_b;
  logic [63:0]     add_sum;
  logic            add_cout;
  logic            accept;
  logic            last_word;

`ifdef ADDER_SEQ_SUB_EN
  logic            sub_q;
`endif

  assign accept    = (state_q == IDLE) && inValid;
  assign last_word = (idx_q == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state logic. DONE returns to IDLE only, so no request can be
  // accepted on the same edge that the result is handed off.
  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE: if (inValid)   next_state = RUN;
      RUN:  if (last_word) next_state = DONE;
      DONE: if (inReady)   next_state = IDLE;
      default:             next_state = IDLE;
    endcase
  end

  // Operand capture. These hold only datapath values that are overwritten
  // on every accept, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      for (int k = 0; k < WORDS; k++) begin
        a_words[k] <= inA[64*k +: 64];
        b_words[k] <= inB[64*k +: 64];
      end
    end
  end

  // Select the current word. In subtract mode B is inverted on its way into
  // the adder; the +1 comes from the carry register loaded on accept.
  always_comb begin
    add_a = a_words[idx_q];
`ifdef ADDER_SEQ_SUB_EN
    add_b = sub_q ? ~b_words[idx_q] : b_words[idx_q];
`else
    add_b = b_words[idx_q];
`endif
  end

  adder_64bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Word sequencing, inter-word carry and result registers. The result is
  // left untouched in IDLE so the last sum stays readable after hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
`ifdef ADDER_SEQ_SUB_EN
      sub_q    <= 1'b0;
`endif
      for (int k = 0; k < WORDS; k++) begin
        sum_words[k] <= 64'd0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (inValid) begin
            idx_q   <= '0;
`ifdef ADDER_SEQ_SUB_EN
            sub_q   <= inSub;
            carry_q <= inSub ? 1'b1 : inCarry;
`else
            carry_q <= inCarry;
`endif
          end
        end
        RUN: begin
          sum_words[idx_q] <= add_sum;
          carry_q          <= add_cout;
          if (last_word) begin
            cout_q <= add_cout;
            idx_q  <= '0;
          end else begin
            idx_q  <= idx_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_sum
    assign outSum[64*g +: 64] = sum_words[g];
  end

  assign outCarry = cout_q;
  assign outReady = (state_q == IDLE);
  assign outValid = (state_q == DONE);
  assign outBusy  = (state_q != IDLE);

endmodule
